// File: rtl/time_set_ctrl.sv
// Mode/sequencing controller for the clock counter chain: 1 Hz tick in RUN,
// set-mode FSM with per-field increment pulses, auto-repeat, blink and timeout.
module time_set_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int BLINK_DIV    = 12500000,
    parameter int TIMEOUT      = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       tick_s,
    output logic       set_s,
    output logic       set_m,
    output logic       set_h,
    output logic [1:0] mode,
    output logic       blink
);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int INACT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t state, next_state;

    logic               mode_q, inc_q;
    logic               mode_rise, inc_rise;
    logic               in_set, stay, timeout, press, fire;
    logic               armed, repeating;
    logic [TICK_W-1:0]  presc;
    logic [HOLD_W-1:0]  hold;
    logic [BLINK_W-1:0] bcnt;
    logic [INACT_W-1:0] inact;

    // The state register doubles as the observable mode output.
    assign mode = state;

    always_comb begin
        mode_rise  = btn_mode & ~mode_q;
        inc_rise   = btn_inc & ~inc_q;
        in_set     = (state != RUN);
        timeout    = in_set && !inc_rise && (inact == INACT_W'(TIMEOUT - 1));
        next_state = state;
        if (mode_rise) begin
            next_state = state_t'(state + 2'd1);
        end else if (timeout) begin
            next_state = RUN;
        end
        stay  = (next_state == state);
        press = in_set && inc_rise && stay;
        // armed drops on any state change, so a held button never repeats into a new field
        fire  = in_set && armed && btn_inc && stay &&
                (repeating ? (hold == HOLD_W'(REPEAT_RATE - 1))
                           : (hold == HOLD_W'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
            presc     <= '0;
            tick_s    <= 1'b0;
            set_s     <= 1'b0;
            set_m     <= 1'b0;
            set_h     <= 1'b0;
            hold      <= '0;
            armed     <= 1'b0;
            repeating <= 1'b0;
            blink     <= 1'b0;
            bcnt      <= '0;
            inact     <= '0;
        end else begin
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
            state  <= next_state;

            if (state == RUN && next_state == RUN) begin
                if (presc == TICK_W'(TICK_DIV - 1)) begin
                    presc  <= '0;
                    tick_s <= 1'b1;
                end else begin
                    presc  <= presc + 1'b1;
                    tick_s <= 1'b0;
                end
            end else begin
                presc  <= '0;
                tick_s <= 1'b0;
            end

            set_h <= (press || fire) && (state == SET_H);
            set_m <= (press || fire) && (state == SET_M);
            set_s <= (press || fire) && (state == SET_S);

            if (press) begin
                hold      <= '0;
                armed     <= 1'b1;
                repeating <= 1'b0;
            end else if (fire) begin
                hold      <= '0;
                repeating <= 1'b1;
            end else if (armed && btn_inc && stay) begin
                hold <= hold + 1'b1;
            end else begin
                hold      <= '0;
                armed     <= 1'b0;
                repeating <= 1'b0;
            end

            if (next_state == RUN) begin
                blink <= 1'b0;
                bcnt  <= '0;
            end else if (!stay) begin
                blink <= 1'b1;
                bcnt  <= '0;
            end else if (bcnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink <= ~blink;
                bcnt  <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end

            if (next_state == RUN || !stay || inc_rise || btn_inc) begin
                inact <= '0;
            end else begin
                inact <= inact + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: pulse stamps are queued when stimulus is
// driven and matched cycle-exactly by a monitor; levels are checked inline.
module tb_time_set_ctrl;
    localparam int W = 36;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic       tick_s, set_s, set_m, set_h, blink;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_obs;
    logic [W-1:0] mon_exp;

    time_set_ctrl #(
        .TICK_DIV    (10),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .BLINK_DIV   (4),
        .TIMEOUT     (100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .tick_s  (tick_s),
        .set_s   (set_s),
        .set_m   (set_m),
        .set_h   (set_h),
        .mode    (mode),
        .blink   (blink)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // kind one-hot: {tick_s, set_h, set_m, set_s}
    task automatic expect_pulse(input logic [3:0] kind, input int t);
        exp_q.push_back({kind, 32'(t)});
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press_mode(input int t);
        wait_until(t);
        btn_mode = 1'b1;
        wait_until(t + 3);
        btn_mode = 1'b0;
    endtask

    // scoreboard monitor: every pulse must match the queue head stamp exactly
    always @(negedge clk) begin
        mon_obs = {tick_s, set_h, set_m, set_s, 32'(cyc)};
        while (exp_q.size() > 0 && exp_q[0][31:0] < 32'(cyc)) begin
            mon_exp = exp_q.pop_front();
            check("missed_pulse", {4'b0000, mon_exp[31:0]}, mon_exp);
        end
        if (exp_q.size() > 0 && exp_q[0][31:0] == 32'(cyc)) begin
            mon_exp = exp_q.pop_front();
            check("pulse", mon_obs, mon_exp);
        end else if (tick_s | set_h | set_m | set_s) begin
            check("unexpected_pulse", mon_obs, {4'b0000, 32'(cyc)});
        end
    end

    initial begin
        int r, c, d, p, f, q, g, h, k, s, u;
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode",  W'(mode), W'(0));
        check("rst_tick",  W'(tick_s), W'(0));
        check("rst_blink", W'(blink), W'(0));
        check("rst_sets",  W'({set_h, set_m, set_s}), W'(0));

        // free-running ticks after release
        rst_n = 1'b1;
        r = cyc;
        expect_pulse(4'b1000, r + 10);
        expect_pulse(4'b1000, r + 20);
        expect_pulse(4'b1000, r + 30);
        wait_until(r + 35);
        check("run_mode", W'(mode), W'(0));

        // mode cycling with blink phase
        c = r + 35;
        for (int i = 0; i < 4; i++) begin
            wait_until(c + 10 * i);
            btn_mode = 1'b1;
            wait_until(c + 10 * i + 1);
            check("mode_step", W'(mode), W'((i + 1) % 4));
            if (i < 3) begin
                check("blink_entry", W'(blink), W'(1));
                wait_until(c + 10 * i + 3);
                btn_mode = 1'b0;
                wait_until(c + 10 * i + 4);
                check("blink_hi_end", W'(blink), W'(1));
                wait_until(c + 10 * i + 5);
                check("blink_lo", W'(blink), W'(0));
                wait_until(c + 10 * i + 8);
                check("blink_lo_end", W'(blink), W'(0));
                wait_until(c + 10 * i + 9);
                check("blink_hi2", W'(blink), W'(1));
            end else begin
                check("blink_run", W'(blink), W'(0));
                wait_until(c + 10 * i + 3);
                btn_mode = 1'b0;
            end
        end
        expect_pulse(4'b1000, c + 41);
        expect_pulse(4'b1000, c + 51);

        // SET_H: hold with auto-repeat
        d = c + 55;
        press_mode(d);
        p = d + 5;
        wait_until(p);
        check("seth_mode", W'(mode), W'(1));
        btn_inc = 1'b1;
        expect_pulse(4'b0100, p + 1);
        expect_pulse(4'b0100, p + 21);
        expect_pulse(4'b0100, p + 26);
        expect_pulse(4'b0100, p + 31);
        expect_pulse(4'b0100, p + 36);
        wait_until(p + 40);
        btn_inc = 1'b0;

        // SET_M: single short press
        f = p + 50;
        press_mode(f);
        q = f + 5;
        wait_until(q);
        check("setm_mode", W'(mode), W'(2));
        btn_inc = 1'b1;
        expect_pulse(4'b0010, q + 1);
        wait_until(q + 2);
        btn_inc = 1'b0;

        // SET_S: simultaneous edges, mode wins; held inc carries no pulses
        g = q + 10;
        press_mode(g);
        h = g + 5;
        wait_until(h);
        check("sets_mode", W'(mode), W'(3));
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        wait_until(h + 1);
        check("simul_mode", W'(mode), W'(0));
        wait_until(h + 3);
        btn_mode = 1'b0;
        wait_until(h + 6);
        btn_mode = 1'b1;
        wait_until(h + 7);
        check("held_entry_mode", W'(mode), W'(1));
        wait_until(h + 9);
        btn_mode = 1'b0;
        wait_until(h + 30);
        btn_inc = 1'b0;

        // inactivity timeout counted from inc release
        wait_until(h + 129);
        check("pre_timeout_mode", W'(mode), W'(1));
        wait_until(h + 130);
        check("timeout_mode",  W'(mode), W'(0));
        check("timeout_blink", W'(blink), W'(0));

        // async reset in the middle of auto-repeat
        k = h + 135;
        press_mode(k);
        s = k + 5;
        wait_until(s);
        btn_inc = 1'b1;
        expect_pulse(4'b0100, s + 1);
        expect_pulse(4'b0100, s + 21);
        wait_until(s + 23);
        rst_n = 1'b0;
        #1;
        check("areset_mode",  W'(mode), W'(0));
        check("areset_blink", W'(blink), W'(0));
        check("areset_pulse", W'({tick_s, set_h, set_m, set_s}), W'(0));
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        u = cyc;
        expect_pulse(4'b1000, u + 10);
        wait_until(u + 1);
        check("post_reset_mode", W'(mode), W'(0));
        wait_until(u + 15);

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Mode/sequencing controller for the seconds/minutes/hours counter chain of the digital clock.
- Generates the 1 Hz tick_s that advances the seconds counter in normal run mode.
- Runs a set-mode state machine driven by two pre-debounced buttons, stops the tick while setting, and issues single-cycle set_s/set_m/set_h increment pulses with press-and-hold auto-repeat.
- Drives a blink enable for the display of the field being edited.

Parameters:
TICK_DIV, 50000000, clk cycles per tick_s period (≥2)
REPEAT_DELAY, 25000000, cycles btn_inc must be held after the press pulse before auto-repeat starts (≥1)
REPEAT_RATE, 10000000, cycles between auto-repeat pulses (≥1)
BLINK_DIV, 12500000, cycles per blink half-period (≥1)
TIMEOUT, 500000000, cycles with no button edge in a set state before forced return to RUN (≥1)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  debounced, clk-synchronous level, active-high; rising edge advances mode
btn_inc  in  1  debounced, clk-synchronous level, active-high; rising edge or hold increments the selected field
tick_s  out  1  one-cycle pulse per second to the seconds counter (RUN only)
set_s  out  1  one-cycle increment pulse, seconds field
set_m  out  1  one-cycle increment pulse, minutes field
set_h  out  1  one-cycle increment pulse, hours field
mode  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
blink  out  1  display blank/show toggle for the edited field; 0 in RUN

Behaviour:
- All outputs registered. Reset (rst_n low, async) forces: state RUN, mode 0, tick_s/set_s/set_m/set_h/blink 0, all internal counters 0, edge-detect history regs 0.
- Edge detect: rise = btn & ~btn_q. btn_q resets to 0, so a button already high at reset release produces an edge on the first cycle.
- FSM on mode_rise: RUN→SET_H→SET_M→SET_S→RUN. mode output equals the state encoding.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN. tick_s=1 for exactly the cycle after the count equals TICK_DIV-1, then the count wraps to 0.
  - In any SET state the prescaler is held at 0 and tick_s=0.
  - On re-entry to RUN the first tick_s occurs TICK_DIV cycles after the transition.
- Increment, in SET states only:
  - inc_rise sampled at cycle n → the selected set_x pulse is high at cycle n+1 for one cycle (SET_H→set_h, SET_M→set_m, SET_S→set_s).
  - At most one set_x is high in any cycle.
  - btn_inc is ignored in RUN.
- Auto-repeat:
  - A hold counter starts at the press. If btn_inc stays high, the first repeat pulse comes REPEAT_DELAY cycles after the press pulse, then one pulse every REPEAT_RATE cycles.
  - btn_inc low clears the hold counter immediately.
- Simultaneous mode_rise and inc_rise: mode wins. State advances, no set pulse, hold counter cleared.
- State change with btn_inc still held: no further pulses until a new inc_rise.
- Blink:
  - On entering a SET state, blink=1 and the blink counter is 0.
  - blink toggles every BLINK_DIV cycles.
  - On entering RUN, blink=0 and the counter is held at 0.
- Timeout:
  - In a SET state the inactivity counter increments each cycle.
  - It clears on any mode_rise or inc_rise, and while btn_inc is held.
  - When it reaches TIMEOUT-1: next state RUN, same exit path as a mode press from SET_S.
  - Counter held at 0 in RUN.
- Counter widths are $clog2 of their maximum values.
- No arithmetic on the time values is done here; wrap at 59/23 is the counters' job.
- Async reset mid-operation aborts any pending pulse; outputs are 0 in the cycle rst_n is low.

Test Plan:
(Use TICK_DIV=10, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_DIV=4, TIMEOUT=100.)
1. Release reset, idle 35 cycles → mode=0, tick_s pulses exactly at cycles 10, 20, 30 after release, never two in a row; set_* stay 0.
2. Four btn_mode presses, 3-cycle pulses 10 cycles apart → mode 1,2,3,0. tick_s silent while mode≠0. First tick_s exactly 10 cycles after return to 0. blink=1 on each SET entry and toggles every 4 cycles.
3. In SET_M, one 2-cycle btn_inc press → a single set_m pulse, one cycle after the press; set_h/set_s stay 0.
4. In SET_H, hold btn_inc for 40 cycles → set_h at press+1, then at +21, +26, +31, +36 (5 pulses total). Release → no more pulses.
5. btn_mode and btn_inc rise in the same cycle while in SET_S → mode becomes 0, no set_s. Inc held high across the change → no pulses.
6. Enter SET_H, no buttons for 100 cycles → mode returns to 0, blink=0. Separately, assert rst_n low mid auto-repeat → all outputs 0 immediately, mode=0 after release.
